decode_issue_queue: RTL and testbench

- Decoupling FIFO between the ID stage and the issue stage, single issue port.
- Accepts decoded scoreboard entries with their original instruction word and control-flow flag.
- Presents them to the issue stage with a valid/ack handshake.
- Throttles issue of control-flow instructions so no more than a configured number are unresolved at once. It drops all contents on a controller flush.

---
 rtl/decode_issue_queue.sv | 88 ++++++++
 tb/tb_decode_issue_queue.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/decode_issue_queue.sv
// ID-to-issue decoupling queue with first-word fall-through head and control-flow issue throttle.
// Push-to-visible latency 1 cycle; ready drops only when full (no pop bypass); a blocked head holds valid low.
module decode_issue_queue #(
  parameter int DEPTH         = 4,
  parameter int SBE_WIDTH     = 256,
  parameter int MAX_CTRL_FLOW = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic                             instr_valid_i,
  input  logic [SBE_WIDTH-1:0]             instr_i,
  input  logic [31:0]                      orig_instr_i,
  input  logic                             is_ctrl_flow_i,
  output logic                             instr_ready_o,
  output logic                             decoded_instr_valid_o,
  output logic [SBE_WIDTH-1:0]             decoded_instr_o,
  output logic [31:0]                      orig_instr_o,
  output logic                             is_ctrl_flow_o,
  input  logic                             decoded_instr_ack_i,
  input  logic                             resolve_branch_i,
  output logic [$clog2(DEPTH):0]           count_o,
  output logic [$clog2(MAX_CTRL_FLOW):0]   ctrl_inflight_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = $clog2(MAX_CTRL_FLOW) + 1;

  logic [SBE_WIDTH-1:0] sbe_mem  [DEPTH];
  logic [31:0]          orig_mem [DEPTH];
  logic [DEPTH-1:0]     ctrl_mem;

  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic [FW-1:0] inflight_q;

  logic not_empty, head_ctrl, blocked, push, pop, inc, dec;

  assign not_empty = (count_q != '0);
  assign head_ctrl = ctrl_mem[rptr_q];
  // A control-flow head waits until an earlier branch resolves.
  assign blocked   = head_ctrl & (inflight_q == FW'(MAX_CTRL_FLOW));

  assign instr_ready_o         = (count_q < CW'(DEPTH));
  assign decoded_instr_valid_o = not_empty & ~blocked;

  assign push = instr_valid_i & instr_ready_o;
  assign pop  = decoded_instr_valid_o & decoded_instr_ack_i;
  assign inc  = pop & head_ctrl;
  assign dec  = resolve_branch_i & (inflight_q != '0);

  assign decoded_instr_o = not_empty ? sbe_mem[rptr_q]  : '0;
  assign orig_instr_o    = not_empty ? orig_mem[rptr_q] : '0;
  assign is_ctrl_flow_o  = not_empty & head_ctrl;

  assign count_o         = count_q;
  assign ctrl_inflight_o = inflight_q;

  // Payload storage needs no reset: occupancy alone qualifies the head.
  always_ff @(posedge clk_i) begin
    if (push) begin
      sbe_mem[wptr_q]  <= instr_i;
      orig_mem[wptr_q] <= orig_instr_i;
      ctrl_mem[wptr_q] <= is_ctrl_flow_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      inflight_q <= '0;
    end else if (flush_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      inflight_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      count_q    <= count_q + CW'(push) - CW'(pop);
      inflight_q <= inflight_q + FW'(inc) - FW'(dec);
    end
  end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Scoreboard bench for decode_issue_queue: reference queue of expected heads plus occupancy/in-flight model.
module tb_decode_issue_queue;

  localparam int DEPTH = 4;
  localparam int SBEW  = 256;
  localparam int MAXC  = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush, ivld, ictrl, ack, resolve;
  logic [SBEW-1:0]  instr;
  logic [31:0]      orig;
  logic             rdy, dvld, octrl;
  logic [SBEW-1:0]  dinstr;
  logic [31:0]      dorig;
  logic [2:0]       count;
  logic [0:0]       infl;

  typedef struct {
    logic [31:0] orig;
    logic        ctrl;
  } exp_t;

  exp_t sbq[$];
  int   infl_m;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  decode_issue_queue #(.DEPTH(DEPTH), .SBE_WIDTH(SBEW), .MAX_CTRL_FLOW(MAXC)) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .flush_i               (flush),
    .instr_valid_i         (ivld),
    .instr_i               (instr),
    .orig_instr_i          (orig),
    .is_ctrl_flow_i        (ictrl),
    .instr_ready_o         (rdy),
    .decoded_instr_valid_o (dvld),
    .decoded_instr_o       (dinstr),
    .orig_instr_o          (dorig),
    .is_ctrl_flow_o        (octrl),
    .decoded_instr_ack_i   (ack),
    .resolve_branch_i      (resolve),
    .count_o               (count),
    .ctrl_inflight_o       (infl)
  );

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
  task automatic step(input logic v, input logic [31:0] o, input logic c,
                      input logic a, input logic r, input logic f);
    logic exp_vld, do_push, do_pop;
    ivld = v; orig = o; ictrl = c; ack = a; resolve = r; flush = f;
    instr = {o ^ 32'hFFFF_0000, {7{o}}};
    @(negedge clk);
    exp_vld = (sbq.size() > 0) && !(sbq[0].ctrl && infl_m == MAXC);
    chk_val("count", 64'(count), 64'(sbq.size()));
    chk_val("inflight", 64'(infl), 64'(infl_m));
    chk_val("ready", 64'(rdy), 64'(sbq.size() < DEPTH));
    chk_val("valid", 64'(dvld), 64'(exp_vld));
    if (sbq.size() > 0) begin
      chk_val("head_orig", 64'(dorig), 64'(sbq[0].orig));
      chk_val("head_ctrl", 64'(octrl), 64'(sbq[0].ctrl));
      chk_val("head_instr_lo", dinstr[63:0], {2{sbq[0].orig}});
      chk_val("head_instr_hi", 64'(dinstr[255:224]), 64'(sbq[0].orig ^ 32'hFFFF_0000));
    end
    do_push = v && (sbq.size() < DEPTH);
    do_pop  = exp_vld && a;
    if (f) begin
      sbq.delete();
      infl_m = 0;
    end else begin
      infl_m = infl_m + ((do_pop && sbq[0].ctrl) ? 1 : 0) - ((r && infl_m > 0) ? 1 : 0);
      if (do_pop)  void'(sbq.pop_front());
      if (do_push) sbq.push_back('{orig: o, ctrl: c});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 0; ivld = 0; ictrl = 0; ack = 0; resolve = 0;
    orig = '0; instr = '0; infl_m = 0;
    #2;
    chk_val("rst_ready", 64'(rdy), 64'd1);
    chk_val("rst_valid", 64'(dvld), 64'd0);
    chk_val("rst_count", 64'(count), 64'd0);
    chk_val("rst_infl", 64'(infl), 64'd0);
    chk_val("rst_orig", 64'(dorig), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill to full with ack held low; a fifth push must be refused.
    for (int i = 0; i < 4; i++) step(1, 32'h11 + i, 0, 0, 0, 0);
    step(1, 32'h15, 0, 0, 0, 0);
    chk_val("full_head", 64'(dorig), 64'h11);
    // Pop from full while offering a push: no push accepted.
    step(1, 32'h16, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk_val("after_pop_head", 64'(dorig), 64'h12);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);

    // Two control-flow entries: the second waits for a resolve.
    step(1, 32'h21, 1, 1, 0, 0);
    step(1, 32'h22, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk_val("b_held_infl", 64'(infl), 64'd1);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    chk_val("b_issued_infl", 64'(infl), 64'd1);

    // Resolve arriving while a control-flow head is blocked, then pop with resolve at zero.
    step(1, 32'h23, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    chk_val("resolve_sat", 64'(infl), 64'd0);

    // Count 3 with one branch in flight, then flush with a simultaneous push.
    step(1, 32'h30, 1, 1, 0, 0);
    step(1, 32'h31, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) step(1, 32'h32 + i, 0, 0, 0, 0);
    step(1, 32'h3F, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    chk_val("flush_count", 64'(count), 64'd0);
    chk_val("flush_infl", 64'(infl), 64'd0);
    chk_val("flush_valid", 64'(dvld), 64'd0);

    // Pointer wrap with back-to-back push/pop.
    for (int i = 0; i < 10; i++) step(1, 32'h40 + i, 0, 1, 0, 0);
    ivld = 0; ack = 0;
    #2 rst_n = 1'b0;
    #1;
    chk_val("arst_ready", 64'(rdy), 64'd1);
    chk_val("arst_valid", 64'(dvld), 64'd0);
    chk_val("arst_count", 64'(count), 64'd0);
    chk_val("arst_infl", 64'(infl), 64'd0);
    sbq.delete();
    infl_m = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 32'h55, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
